// File: rtl/dpram_burst_reader.sv
// Burst read master for one elastic_dpram port: issues consecutive reads and
// returns responses through a credit-protected FIFO as a valid/ready stream.
module dpram_burst_reader #(
   parameter int DEPTH      = 2048,
   parameter int AW         = 11,
   parameter int DW         = 32,
   parameter int LW         = 12,
   parameter int FIFO_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] cmd_addr,
   input  logic [LW-1:0] cmd_len,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   output logic [AW-1:0] t_addr,
   output logic [DW-1:0] t_data,
   output logic          t_we,
   output logic          t_valid,
   input  logic          t_ready,
   input  logic [AW-1:0] i_addr,
   input  logic [DW-1:0] i_data,
   input  logic          i_valid,
   output logic          i_ready,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_data,
   output logic          m_last,
   output logic          m_valid,
   input  logic          m_ready,
   output logic          busy,
   output logic          done,
   output logic          err
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t        state;
   logic [AW-1:0] req_addr;
   logic [LW-1:0] req_rem;
   logic [LW-1:0] burst_len;
   logic [LW-1:0] ret_cnt;
   logic [CW-1:0] fifo_cnt;
   logic [CW-1:0] outst;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [AW-1:0] f_addr [FIFO_DEPTH];
   logic [DW-1:0] f_data [FIFO_DEPTH];
   logic          f_last [FIFO_DEPTH];

   logic [CW:0]   credit_sum;
   logic          credit;
   logic          req_hs;
   logic          rsp_ok;
   logic          full;
   logic          pop;
   logic          push;
   logic          rsp_last;

   always_comb begin
      credit_sum = {1'b0, fifo_cnt} + {1'b0, outst};
      credit     = credit_sum < (CW+1)'(FIFO_DEPTH);
      t_valid    = (state == ISSUE) && credit;
      t_addr     = req_addr;
      t_data     = '0;
      t_we       = 1'b0;
      req_hs     = t_valid && t_ready;
      rsp_ok     = i_valid && (outst != '0);
      full       = fifo_cnt == CW'(FIFO_DEPTH);
      m_valid    = fifo_cnt != '0;
      pop        = m_valid && m_ready;
      push       = rsp_ok && (!full || pop);
      rsp_last   = ret_cnt == (burst_len - 1'b1);
      m_addr     = f_addr[rd_ptr];
      m_data     = f_data[rd_ptr];
      m_last     = f_last[rd_ptr];
      busy       = state != IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         req_addr  <= '0;
         req_rem   <= '0;
         burst_len <= '0;
         ret_cnt   <= '0;
         fifo_cnt  <= '0;
         outst     <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         cmd_ready <= 1'b0;
         i_ready   <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            f_addr[i] <= '0;
            f_data[i] <= '0;
            f_last[i] <= 1'b0;
         end
      end else begin
         i_ready <= 1'b1;
         done    <= 1'b0;

         outst    <= outst + CW'(req_hs) - CW'(rsp_ok);
         fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
         if (push) begin
            f_addr[wr_ptr] <= i_addr;
            f_data[wr_ptr] <= i_data;
            f_last[wr_ptr] <= rsp_last;
            wr_ptr         <= wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (rsp_ok)
            ret_cnt <= ret_cnt + 1'b1;

         // Stray responses are only an error while a burst is active.
         if ((i_valid && outst == '0 && state != IDLE) || (rsp_ok && full && !pop))
            err <= 1'b1;

         case (state)
            IDLE: begin
               cmd_ready <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  req_addr  <= cmd_addr;
                  req_rem   <= cmd_len;
                  burst_len <= cmd_len;
                  ret_cnt   <= '0;
                  if (cmd_len == '0) begin
                     done <= 1'b1;
                  end else begin
                     cmd_ready <= 1'b0;
                     state     <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               if (req_hs) begin
                  req_addr <= (req_addr == LAST_ADDR) ? '0 : req_addr + 1'b1;
                  req_rem  <= req_rem - 1'b1;
                  if (req_rem == LW'(1))
                     state <= DRAIN;
               end
            end
            DRAIN: begin
               if (pop && m_last) begin
                  done      <= 1'b1;
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dpram_burst_reader.sv
// Directed bench for dpram_burst_reader with a 1-cycle-latency RAM responder.
module tb_dpram_burst_reader;
   localparam int AW = 11;
   localparam int DW = 32;
   localparam int LW = 12;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [LW-1:0] cmd_len = '0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [AW-1:0] t_addr;
   logic [DW-1:0] t_data;
   logic          t_we;
   logic          t_valid;
   logic          t_ready = 1'b1;
   logic [AW-1:0] i_addr;
   logic [DW-1:0] i_data;
   logic          i_valid;
   logic          i_ready;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;
   logic          m_last;
   logic          m_valid;
   logic          m_ready = 1'b1;
   logic          busy;
   logic          done;
   logic          err;

   logic          rsp_valid;
   logic [AW-1:0] rsp_addr;
   logic [DW-1:0] rsp_data;
   logic          inj_valid = 1'b0;
   logic [AW-1:0] inj_addr = '0;
   logic [DW-1:0] inj_data = '0;

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;
   int done_cnt = 0;
   int hold_viol = 0;
   int stall_cnt = 0;
   logic          hold_pend = 1'b0;
   logic [AW-1:0] hold_addr = '0;

   logic [AW-1:0] m_addr_q[$];
   logic [DW-1:0] m_data_q[$];
   logic          m_last_q[$];
   int            m_cyc_q[$];
   logic [AW-1:0] t_addr_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dpram_burst_reader #(
      .DEPTH(2048), .AW(AW), .DW(DW), .LW(LW), .FIFO_DEPTH(4)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .t_addr(t_addr), .t_data(t_data), .t_we(t_we), .t_valid(t_valid), .t_ready(t_ready),
      .i_addr(i_addr), .i_data(i_data), .i_valid(i_valid), .i_ready(i_ready),
      .m_addr(m_addr), .m_data(m_data), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
      .busy(busy), .done(done), .err(err)
   );

   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      return {a, 21'h0} ^ 32'h1234_5678 ^ {21'h0, a};
   endfunction

   // RAM responder: one response per accepted request, one cycle later.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_addr  <= '0;
         rsp_data  <= '0;
      end else begin
         rsp_valid <= t_valid && t_ready;
         rsp_addr  <= t_addr;
         rsp_data  <= mem_word(t_addr);
      end
   end

   assign i_valid = rsp_valid | inj_valid;
   assign i_addr  = inj_valid ? inj_addr : rsp_addr;
   assign i_data  = inj_valid ? inj_data : rsp_data;

   always @(negedge clk) begin
      if (rst_n) begin
         if (m_valid && m_ready) begin
            m_addr_q.push_back(m_addr);
            m_data_q.push_back(m_data);
            m_last_q.push_back(m_last);
            m_cyc_q.push_back(cyc);
         end
         if (t_valid && t_ready) t_addr_q.push_back(t_addr);
         if (done) done_cnt++;
         if (hold_pend && (!t_valid || t_addr != hold_addr)) hold_viol++;
         if (t_valid && !t_ready) stall_cnt++;
         hold_pend = t_valid && !t_ready;
         hold_addr = t_addr;
      end else begin
         hold_pend = 1'b0;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_logs();
      m_addr_q.delete();
      m_data_q.delete();
      m_last_q.delete();
      m_cyc_q.delete();
      t_addr_q.delete();
      hold_viol = 0;
      stall_cnt = 0;
   endtask

   task automatic run_cmd(input logic [AW-1:0] a, input logic [LW-1:0] l, output int n);
      n = -1;
      @(posedge clk); #1;
      cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (cmd_ready) begin n = cyc; break; end
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      if (n < 0) check("cmd_timeout", 64'd0, 64'd1);
   endtask

   task automatic wait_done(input int budget, output int dc);
      dc = -1;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (done) begin dc = cyc; break; end
      end
      if (dc < 0) check("done_timeout", 64'd0, 64'd1);
   endtask

   task automatic check_words(input string tag, input logic [AW-1:0] base, input int len);
      logic [AW-1:0] a;
      check({tag, "_count"}, 64'(m_addr_q.size()), 64'(len));
      if (m_addr_q.size() == len) begin
         for (int i = 0; i < len; i++) begin
            a = base + AW'(i);
            check({tag, "_addr"}, 64'(m_addr_q[i]), 64'(a));
            check({tag, "_data"}, 64'(m_data_q[i]), 64'(mem_word(a)));
            check({tag, "_last"}, 64'(m_last_q[i]), 64'(i == len - 1));
         end
      end
   endtask

   initial begin
      int n;
      int dc;
      int done_base;
      logic [AW-1:0] exp_t [4];

      repeat (2) @(posedge clk);
      #1;
      check("rst_ctl", 64'({cmd_ready, t_valid, t_we, i_ready, m_last, m_valid, busy, done, err}), 64'd0);
      check("rst_addr", 64'({t_addr, m_addr}), 64'd0);
      check("rst_data", 64'(m_data), 64'd0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // 1: basic burst latency and ordering
      clear_logs();
      run_cmd(11'h010, 12'd4, n);
      wait_done(50, dc);
      check_words("t1", 11'h010, 4);
      if (m_cyc_q.size() == 4)
         for (int i = 0; i < 4; i++) check("t1_cycle", 64'(m_cyc_q[i]), 64'(n + 3 + i));
      check("t1_done_cycle", 64'(dc), 64'(n + 7));
      check("t1_err", 64'(err), 64'd0);

      // 2: address wrap at the top of memory
      clear_logs();
      run_cmd(11'h7FE, 12'd4, n);
      wait_done(50, dc);
      exp_t[0] = 11'h7FE; exp_t[1] = 11'h7FF; exp_t[2] = 11'h000; exp_t[3] = 11'h001;
      check("t2_req_count", 64'(t_addr_q.size()), 64'd4);
      if (t_addr_q.size() == 4)
         for (int i = 0; i < 4; i++) check("t2_t_addr", 64'(t_addr_q[i]), 64'(exp_t[i]));
      check_words("t2", 11'h7FE, 4);

      // 3: backpressure limits requests in flight to FIFO depth
      clear_logs();
      m_ready = 1'b0;
      run_cmd(11'h100, 12'd16, n);
      repeat (12) @(negedge clk);
      check("t3_req_stalled", 64'(t_addr_q.size()), 64'd4);
      check("t3_t_valid", 64'(t_valid), 64'd0);
      check("t3_head", 64'({m_valid, m_addr}), 64'({1'b1, 11'h100}));
      check("t3_head_data", 64'(m_data), 64'(mem_word(11'h100)));
      @(posedge clk); #1;
      m_ready = 1'b1;
      wait_done(200, dc);
      check_words("t3", 11'h100, 16);
      check("t3_err", 64'(err), 64'd0);

      // 4: t_ready toggling every cycle
      clear_logs();
      run_cmd(11'h200, 12'd8, n);
      dc = -1;
      for (int k = 0; k < 200; k++) begin
         @(posedge clk); #1;
         t_ready = ~t_ready;
         @(negedge clk);
         if (done) begin dc = cyc; break; end
      end
      if (dc < 0) check("t4_done_timeout", 64'd0, 64'd1);
      t_ready = 1'b1;
      check("t4_stalls_seen", 64'(stall_cnt > 0), 64'd1);
      check("t4_hold_viol", 64'(hold_viol), 64'd0);
      check_words("t4", 11'h200, 8);

      // 5: zero-length command
      clear_logs();
      run_cmd(11'h300, 12'd0, n);
      @(negedge clk);
      check("t5_done_pulse", 64'({done, cmd_ready, busy}), 64'b110);
      check("t5_done_cycle", 64'(cyc), 64'(n + 1));
      @(negedge clk);
      check("t5_done_end", 64'({done, cmd_ready, busy}), 64'b010);
      repeat (3) @(negedge clk);
      check("t5_no_req", 64'(t_addr_q.size()), 64'd0);

      // 6: asynchronous reset mid-burst, stray response after release
      clear_logs();
      run_cmd(11'h400, 12'd16, n);
      repeat (3) @(negedge clk);
      check("t6_busy", 64'(busy), 64'd1);
      done_base = done_cnt;
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_ctl", 64'({cmd_ready, t_valid, i_ready, m_last, m_valid, busy, done, err}), 64'd0);
      check("t6_rst_bus", 64'({t_addr, m_addr}), 64'd0);
      check("t6_rst_data", 64'(m_data), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      inj_valid = 1'b1; inj_addr = 11'h555; inj_data = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      inj_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("t6_after", 64'({err, m_valid, busy, i_ready, cmd_ready}), 64'b00011);
      check("t6_no_done", 64'(done_cnt), 64'(done_base));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
endmodule
